// File: rtl/pixel_pool_pkg.sv
// Shared constants and enumerations for the pixel_pool crop/pool/threshold pipeline.
package pixel_pool_pkg;

   localparam int unsigned DEF_IN_W    = 10;
   localparam int unsigned DEF_OUT_W   = 8;
   localparam int unsigned DEF_SRC_H   = 640;
   localparam int unsigned DEF_SRC_V   = 480;
   localparam int unsigned DEF_CROP_H0 = 96;
   localparam int unsigned DEF_CROP_V0 = 16;
   localparam int unsigned DEF_CROP_N  = 448;
   localparam int unsigned DEF_OUT_N   = 28;
   localparam int unsigned DEF_THRESH  = 100;

   typedef enum logic {
      MODE_DECIMATE = 1'b0,
      MODE_AVERAGE  = 1'b1
   } mode_e;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } state_e;

endpackage

// File: rtl/pixel_pool_rgb2grey_bw.sv
// Combinational colour-to-grey conversion and grey-to-black/white threshold.
module rgb2grey_bw
   import pixel_pool_pkg::*;
#(
   parameter int unsigned IN_W   = DEF_IN_W,
   parameter int unsigned OUT_W  = DEF_OUT_W,
   parameter int unsigned THRESH = DEF_THRESH
) (
   input  logic [IN_W-1:0]  i_red,
   input  logic [IN_W-1:0]  i_green,
   input  logic [IN_W-1:0]  i_blue,
   input  logic [OUT_W-1:0] i_pool_grey,
   output logic [OUT_W-1:0] o_grey,
   output logic [OUT_W-1:0] o_pool_bw
);

   logic [IN_W+1:0] w_sum;

   function automatic logic [OUT_W-1:0] thresh_bw(input logic [OUT_W-1:0] grey);
      return (32'(grey) > THRESH) ? '1 : '0;
   endfunction

   // Separate assigns keep the grey path independent of the pooled-grey input.
   assign w_sum     = {2'b00, i_red} + {1'b0, i_green, 1'b0} + {2'b00, i_blue};
   assign o_grey    = w_sum[IN_W+1 -: OUT_W];
   assign o_pool_bw = thresh_bw(i_pool_grey);

endmodule

// File: rtl/pixel_pool.sv
// Streams a frame, crops a square window and pools BLKxBLK blocks (decimate or average) to grey/bw.
module pixel_pool
   import pixel_pool_pkg::*;
#(
   parameter int unsigned IN_W    = DEF_IN_W,
   parameter int unsigned OUT_W   = DEF_OUT_W,
   parameter int unsigned SRC_H   = DEF_SRC_H,
   parameter int unsigned SRC_V   = DEF_SRC_V,
   parameter int unsigned CROP_H0 = DEF_CROP_H0,
   parameter int unsigned CROP_V0 = DEF_CROP_V0,
   parameter int unsigned CROP_N  = DEF_CROP_N,
   parameter int unsigned OUT_N   = DEF_OUT_N,
   parameter int unsigned THRESH  = DEF_THRESH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic                     in_sof,
   input  logic [IN_W-1:0]          iRed,
   input  logic [IN_W-1:0]          iGreen,
   input  logic [IN_W-1:0]          iBlue,
   input  logic                     in_mode,
   output logic                     out_valid,
   output logic [OUT_W-1:0]         out_grey,
   output logic [OUT_W-1:0]         out_bw,
   output logic [$clog2(OUT_N)-1:0] out_x,
   output logic [$clog2(OUT_N)-1:0] out_y,
   output logic                     frame_done,
   output logic                     busy
);

   localparam int unsigned BLK   = CROP_N / OUT_N;
   localparam int unsigned LOG2B = $clog2(BLK);
   localparam int unsigned XW    = $clog2(OUT_N);
   localparam int unsigned HW    = $clog2(SRC_H + 1);
   localparam int unsigned VW    = $clog2(SRC_V + 1);
   localparam int unsigned AW    = OUT_W + 2 * LOG2B;

   // Intra-block offsets are bit slices, so BLK must be an exact power of two of at least 2.
   if (BLK < 2 || (1 << LOG2B) != BLK || BLK * OUT_N != CROP_N) begin : g_bad_blk
      $error("pixel_pool: CROP_N/OUT_N must be an exact power of two >= 2");
   end

   state_e           r_state, w_next;
   mode_e            r_mode, w_mode;
   logic [HW-1:0]    r_hcnt, w_h, w_hoff;
   logic [VW-1:0]    r_vcnt, w_v, w_voff;
   logic             w_sof, w_acc, w_crop, w_first, w_last, w_eof, w_done_blk;
   logic [XW-1:0]    w_col, w_row;
   logic [AW-1:0]    r_acc [OUT_N];
   logic [OUT_W-1:0] r_dec [OUT_N];
   logic [AW-1:0]    w_sum;
   logic [OUT_W-1:0] w_grey, w_dec, w_result, w_bw;

   rgb2grey_bw #(
      .IN_W   (IN_W),
      .OUT_W  (OUT_W),
      .THRESH (THRESH)
   ) u_grey (
      .i_red       (iRed),
      .i_green     (iGreen),
      .i_blue      (iBlue),
      .i_pool_grey (w_result),
      .o_grey      (w_grey),
      .o_pool_bw   (w_bw)
   );

   // The in_sof pixel is position (0,0) of the new frame regardless of the counters.
   always_comb begin
      w_sof      = in_valid & in_sof;
      w_acc      = in_valid & (in_sof | (r_state == ST_STREAM));
      w_h        = w_sof ? '0 : r_hcnt;
      w_v        = w_sof ? '0 : r_vcnt;
      w_mode     = w_sof ? mode_e'(in_mode) : r_mode;
      w_crop     = (w_h >= HW'(CROP_H0)) && (w_h < HW'(CROP_H0 + CROP_N)) &&
                   (w_v >= VW'(CROP_V0)) && (w_v < VW'(CROP_V0 + CROP_N));
      w_hoff     = w_h - HW'(CROP_H0);
      w_voff     = w_v - VW'(CROP_V0);
      w_col      = XW'(w_hoff >> LOG2B);
      w_row      = XW'(w_voff >> LOG2B);
      w_first    = (w_hoff[LOG2B-1:0] == '0) && (w_voff[LOG2B-1:0] == '0);
      w_last     = (&w_hoff[LOG2B-1:0]) && (&w_voff[LOG2B-1:0]);
      w_done_blk = w_acc && w_crop && w_last;
      w_sum      = (w_first ? '0 : r_acc[w_col]) + AW'(w_grey);
      w_dec      = w_first ? w_grey : r_dec[w_col];
      w_result   = (w_mode == MODE_AVERAGE) ? w_sum[AW-1 -: OUT_W] : w_dec;
      w_eof      = (w_h == HW'(SRC_H - 1)) && (w_v == VW'(SRC_V - 1));
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:   if (w_sof) w_next = ST_STREAM;
         ST_STREAM: if (w_acc && w_eof) w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hcnt <= '0;
         r_vcnt <= '0;
         r_mode <= MODE_DECIMATE;
      end else if (w_acc) begin
         r_mode <= w_mode;
         if (w_h == HW'(SRC_H - 1)) begin
            r_hcnt <= '0;
            r_vcnt <= (w_v == VW'(SRC_V - 1)) ? '0 : w_v + 1'b1;
         end else begin
            r_hcnt <= w_h + 1'b1;
            r_vcnt <= w_v;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < OUT_N; i++) begin
            r_acc[i] <= '0;
            r_dec[i] <= '0;
         end
      end else begin
         if (w_sof) begin
            for (int unsigned i = 0; i < OUT_N; i++) begin
               r_acc[i] <= '0;
               r_dec[i] <= '0;
            end
         end
         if (w_acc && w_crop) begin
            r_acc[w_col] <= w_sum;
            if (w_first) r_dec[w_col] <= w_grey;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid  <= 1'b0;
         frame_done <= 1'b0;
         out_grey   <= '0;
         out_bw     <= '0;
         out_x      <= '0;
         out_y      <= '0;
      end else begin
         out_valid  <= w_done_blk;
         frame_done <= w_done_blk && (w_col == XW'(OUT_N - 1)) && (w_row == XW'(OUT_N - 1));
         if (w_done_blk) begin
            out_grey <= w_result;
            out_bw   <= w_bw;
            out_x    <= w_col;
            out_y    <= w_row;
         end
      end
   end

   assign busy = (r_state == ST_STREAM);

endmodule
